stream_demux: RTL
=================

Name: stream_demux

Overview:
- Valid/ready stream demultiplexer: steers each word from one input stream to one of N output lanes, chosen by a per-word select.
- Each lane has a small FIFO, so a stalled consumer blocks only its own lane.
- Sits between a shared producer (e.g. a bus response path) and N independent consumers; fans traffic out where the generic selectors fan it in.

Parameters:
- WIDTH, 8, data width in bits.
- N, 4, number of output lanes; legal range 2..8.
- DEPTH, 2, entries per lane FIFO; power of 2, legal range 1..8.
- SELW, $clog2(N), select width; derived, never overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- InValid  input  1  input word present.
- InReady  output  1  block can take the input word this cycle.
- InData  input  WIDTH  input word.
- InSel  input  SELW  destination lane index.
- OutValid  output  N  bit i: lane i head is valid.
- OutReady  input  N  bit i: consumer i takes the head this cycle.
- OutData  output  N*WIDTH  lane i head word, in bits [i*WIDTH +: WIDTH].
- SelErr  output  1  one-cycle pulse: a word with out-of-range InSel was discarded.

Behaviour:
- Reset (synchronous, active-high):
  - All lane counts, read pointers and write pointers clear to 0; storage clears to 0.
  - OutValid = 0, OutData = 0, SelErr = 0.
  - Reset mid-operation discards all buffered words. No accepts or pops occur in a reset cycle.
- Per-lane state: count 0..DEPTH, read pointer, write pointer; pointers wrap modulo DEPTH. full = (count == DEPTH), empty = (count == 0).
- InReady is combinational from InSel and lane state:
  - In-range InSel: InReady = !full[InSel].
  - InSel >= N: InReady = 1.
  - InReady does not depend on InValid.
- Accept = InValid & InReady. On accept with in-range InSel, InData is written at lane InSel's write pointer, the write pointer advances, and the count increments.
- Out-of-range accept: the word is dropped; SelErr is registered high for exactly the next cycle.
- Outputs per lane:
  - OutValid[i] = !empty[i].
  - OutData lane i = storage at read pointer i.
  - Pop = OutValid[i] & OutReady[i]; the read pointer advances and the count decrements.
- Latency: an accepted word appears on OutValid/OutData on the cycle after accept. There is no same-cycle pass-through, even when the lane is empty.
- Simultaneous push and pop on the same lane:
  - Count unchanged, both pointers advance.
  - On a full lane the push is refused (InReady = 0), so only the pop occurs; the lane accepts again next cycle.
- Pops on different lanes are independent and may all occur in the same cycle.
- Per-lane ordering is strictly FIFO. No ordering guarantee across lanes.
- Once OutValid[i] is asserted, OutValid[i] and OutData lane i stay stable until popped. OutReady may toggle freely.
- Count never exceeds DEPTH and never goes below 0. A pop on an empty lane is ignored.

Optional Feature:
- Macro: STREAM_DEMUX_BROADCAST_EN.
- Defined:
  - Adds input port InBcast (1 bit).
  - When InBcast = 1, the word goes to all N lanes in one cycle. InReady = 1 only if no lane is full; InSel is ignored and SelErr is not raised.
  - On accept, every lane pushes the word (each may pop concurrently).
  - InBcast = 0 behaves exactly as described above.
- Not defined: port InBcast is absent and behaviour is exactly as described above.

Test Plan (WIDTH=8, N=4, DEPTH=2 unless stated):
- Reset then idle -> OutValid=4'b0000, OutData=0, SelErr=0, InReady=1 for every InSel.
- Push 0xA1 to lane 2 with all OutReady=1 -> OutValid=4'b0100 and lane-2 data 0xA1 the next cycle; popped the following edge; OutValid returns to 0.
- Lane 1 held with OutReady[1]=0; push 0x11, 0x22, then 0x33 to lane 1 -> InReady drops to 0 after two accepts; 0x33 is held; lane 0 still accepts 0x44. Release OutReady[1] -> 0x11, 0x22, 0x33 pop in order.
- Lane 3 full; same cycle OutReady[3]=1 and InValid with InSel=3 -> pop only, count 1; next cycle push accepted, count 2.
- N=3, InSel=3, InData=0x55 -> accepted (InReady=1), SelErr=1 for exactly one cycle, no OutValid change.
- Reset asserted with lanes 0 and 1 holding 2 words each -> OutValid=0 after the edge; subsequent push 0x77 to lane 0 emerges first.
- With STREAM_DEMUX_BROADCAST_EN: InBcast=1, InData=0x9C, lane 0 full -> InReady=0. Pop lane 0 -> next accept pushes 0x9C into all four lanes.

Source files
------------

// File: rtl/stream_demux.sv
// stream_demux: valid/ready stream demultiplexer.
// Each input word is steered to one of N output lanes chosen by InSel. Every
// lane owns a DEPTH-entry FIFO, so a stalled consumer only blocks its own lane.
// Words with an out-of-range InSel are accepted and dropped, and SelErr pulses
// for one cycle afterwards.
//
// Optional build macro: STREAM_DEMUX_BROADCAST_EN adds InBcast. When it is set,
// the word is pushed into every lane at once.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   InValid   input word present
//   InReady   block can take the input word this cycle (combinational)
//   InData    input word
//   InSel     destination lane index
//   InBcast   (broadcast builds only) push the word into all lanes
//   OutValid  bit i: lane i head is valid
//   OutReady  bit i: consumer i takes the head this cycle
//   OutData   lane i head word in bits [i*WIDTH +: WIDTH]
//   SelErr    one-cycle pulse after an out-of-range word is dropped
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int DEPTH = 2,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               InValid,
  output logic               InReady,
  input  logic [WIDTH-1:0]   InData,
  input  logic [SELW-1:0]    InSel,
`ifdef STREAM_DEMUX_BROADCAST_EN
  input  logic               InBcast,
`endif
  output logic [N-1:0]       OutValid,
  input  logic [N-1:0]       OutReady,
  output logic [N*WIDTH-1:0] OutData,
  output logic               SelErr
);

  // A single-entry FIFO still needs a one-bit pointer; it just never moves.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [N][DEPTH];
  logic [WIDTH-1:0] mem_d [N][DEPTH];
  logic [PW-1:0]    rd_ptr_q [N];
  logic [PW-1:0]    rd_ptr_d [N];
  logic [PW-1:0]    wr_ptr_q [N];
  logic [PW-1:0]    wr_ptr_d [N];
  logic [CW-1:0]    cnt_q [N];
  logic [CW-1:0]    cnt_d [N];
  logic             sel_err_q;
  logic             sel_err_d;

  logic             bcast;
  logic             sel_in_range;
  logic             sel_full;
  logic             any_full;
  logic             accept;
  logic [N-1:0]     full;
  logic [N-1:0]     push;
  logic [N-1:0]     pop;

`ifdef STREAM_DEMUX_BROADCAST_EN
  assign bcast = InBcast;
`else
  assign bcast = 1'b0;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign sel_in_range = (int'(InSel) < N);

  // Lane lookup by loop rather than full[InSel] so out-of-range selects never
  // index past the vector.
  always_comb begin
    sel_full = 1'b0;
    any_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      full[i]  = (cnt_q[i] == CW'(DEPTH));
      any_full = any_full | full[i];
      if (int'(InSel) == i) sel_full = full[i];
    end
  end

  always_comb begin
    if (bcast)             InReady = !any_full;
    else if (sel_in_range) InReady = !sel_full;
    else                   InReady = 1'b1;
  end

  assign accept    = InValid & InReady;
  assign sel_err_d = accept & !bcast & !sel_in_range;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      push[i] = accept & (bcast | (sel_in_range & (int'(InSel) == i)));
      pop[i]  = (cnt_q[i] != '0) & OutReady[i];
    end
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = InData;
        wr_ptr_d[i]           = ptr_inc(wr_ptr_q[i]);
      end
      if (pop[i]) rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
      if (push[i] && !pop[i])      cnt_d[i] = cnt_q[i] + CW'(1);
      else if (pop[i] && !push[i]) cnt_d[i] = cnt_q[i] - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      sel_err_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      sel_err_q <= sel_err_d;
    end
  end

  always_comb begin
    OutData = '0;
    for (int i = 0; i < N; i++) begin
      OutValid[i]                = (cnt_q[i] != '0);
      OutData[i*WIDTH +: WIDTH]  = mem_q[i][rd_ptr_q[i]];
    end
  end

  assign SelErr = sel_err_q;

endmodule
